// File: rtl/outbox_fifo.sv
// OUTBOX responder: buffers CPU words written on wO and presents them on a
// first-word-fall-through valid/ready port, with full backpressure and a sticky drop flag.
module outbox_fifo #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_rst_n,
  input  logic          clr,
  input  logic          wO,
  input  logic [7:0]    din,
  output logic          outFull,
  output logic [7:0]    o_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [AW:0]   count,
  output logic          ovf
);

  localparam logic [AW:0]   DepthCount = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CountOne   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PtrOne     = {{(AW-1){1'b0}}, 1'b1};

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wrPtr_r;
  logic [AW-1:0] rdPtr_r;
  logic [AW:0]   count_r;
  logic [AW:0]   countNext_s;
  logic          full_r;
  logic          valid_r;
  logic          ovf_r;
  logic          push_s;
  logic          pop_s;

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign pop_s  = valid_r && i_ready;
  assign push_s = wO && (!full_r || pop_s);

  // Next occupancy from the push/pop pair; drives count and the decoded flags.
  always_comb begin
    countNext_s = count_r;
    case ({push_s, pop_s})
      2'b10:   countNext_s = count_r + CountOne;
      2'b01:   countNext_s = count_r - CountOne;
      default: countNext_s = count_r;
    endcase
  end

  // Pointers, occupancy, sticky overflow and the registered full/valid flags.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wrPtr_r <= {AW{1'b0}};
      rdPtr_r <= {AW{1'b0}};
      count_r <= {(AW+1){1'b0}};
      full_r  <= 1'b0;
      valid_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (clr) begin
      wrPtr_r <= {AW{1'b0}};
      rdPtr_r <= {AW{1'b0}};
      count_r <= {(AW+1){1'b0}};
      full_r  <= 1'b0;
      valid_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      if (push_s) begin
        wrPtr_r <= wrPtr_r + PtrOne;
      end else begin
        wrPtr_r <= wrPtr_r;
      end
      if (pop_s) begin
        rdPtr_r <= rdPtr_r + PtrOne;
      end else begin
        rdPtr_r <= rdPtr_r;
      end
      if (wO && !push_s) begin
        ovf_r <= 1'b1;
      end else begin
        ovf_r <= ovf_r;
      end
      count_r <= countNext_s;
      full_r  <= (countNext_s == DepthCount);
      valid_r <= (countNext_s != {(AW+1){1'b0}});
    end
  end

  // Storage array is deliberately left without reset; a flush discards the write.
  always_ff @(posedge clk) begin
    if (push_s && !clr) begin
      mem_r[wrPtr_r] <= din;
    end else begin
      mem_r[wrPtr_r] <= mem_r[wrPtr_r];
    end
  end

  assign o_data  = mem_r[rdPtr_r];
  assign o_valid = valid_r;
  assign outFull = full_r;
  assign count   = count_r;
  assign ovf     = ovf_r;

endmodule

// File: tb/tb_outbox_fifo.sv
// Self-checking bench for outbox_fifo: directed scenarios plus random traffic,
// compared against a queue-based model of the FIFO.
module tb_outbox_fifo;

  localparam int DEPTH = 8;

  logic       clk;
  logic       i_rst_n;
  logic       clr;
  logic       wO;
  logic [7:0] din;
  logic       outFull;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic [3:0] count;
  logic       ovf;

  int checkCnt = 0;
  int errCnt   = 0;

  logic [7:0] model[$];
  logic       mOvf;
  int         maxCount;

  outbox_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .i_rst_n(i_rst_n), .clr(clr), .wO(wO), .din(din),
    .outFull(outFull), .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .count(count), .ovf(ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCnt++;
    if (obs !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare every visible output against the model state.
  task automatic checkState(input string tag);
    checkValue({tag, ".count"}, 32'(count), 32'(model.size()));
    checkValue({tag, ".outFull"}, 32'(outFull), 32'(model.size() == DEPTH));
    checkValue({tag, ".o_valid"}, 32'(o_valid), 32'(model.size() != 0));
    checkValue({tag, ".ovf"}, 32'(ovf), 32'(mOvf));
    if (model.size() != 0) checkValue({tag, ".o_data"}, 32'(o_data), 32'(model[0]));
    if (model.size() > maxCount) maxCount = model.size();
  endtask

  // One clock: predict from current inputs, advance, then check after the edge.
  task automatic step(input string tag);
    bit mPop;
    bit mPush;
    mPop  = (model.size() != 0) && i_ready;
    mPush = wO && ((model.size() < DEPTH) || mPop);
    if (clr) begin
      model.delete();
      mOvf = 1'b0;
    end else begin
      if (mPop) begin
        checkValue({tag, ".popData"}, 32'(o_data), 32'(model[0]));
        void'(model.pop_front());
      end
      if (mPush) model.push_back(din);
      if (wO && !mPush) mOvf = 1'b1;
    end
    @(posedge clk);
    #1;
    checkState(tag);
  endtask

  task automatic idleInputs();
    wO = 1'b0; i_ready = 1'b0; clr = 1'b0; din = 8'h00;
  endtask

  initial begin
    int written;
    logic [7:0] nextVal;
    i_rst_n = 1'b0;
    idleInputs();
    mOvf = 1'b0;
    maxCount = 0;

    // Reset then idle
    repeat (2) @(posedge clk);
    #1;
    checkState("inReset");
    i_rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step("idle");

    // Single word
    wO = 1'b1; din = 8'h2A;
    step("single.write");
    wO = 1'b0;
    checkValue("single.data", 32'(o_data), 32'h2A);
    checkValue("single.count", 32'(count), 32'd1);
    i_ready = 1'b1;
    step("single.pop");
    checkValue("single.empty", 32'(o_valid), 32'd0);
    i_ready = 1'b0;

    // Fill and overflow
    for (int i = 1; i <= 8; i++) begin
      wO = 1'b1; din = 8'(i);
      step("fill");
    end
    checkValue("fill.full", 32'(outFull), 32'd1);
    checkValue("fill.count", 32'(count), 32'd8);
    din = 8'h09;
    step("overflow");
    checkValue("overflow.ovf", 32'(ovf), 32'd1);
    wO = 1'b0; i_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      checkValue("drain.seq", 32'(o_data), 32'(i));
      step("drain");
    end
    checkValue("drain.empty", 32'(o_valid), 32'd0);
    i_ready = 1'b0; clr = 1'b1;
    step("clrOvf");
    clr = 1'b0;
    checkValue("clrOvf.ovf", 32'(ovf), 32'd0);

    // Full with simultaneous push and pop
    for (int i = 0; i < 8; i++) begin
      wO = 1'b1; din = 8'h10 + 8'(i);
      step("fill2");
    end
    din = 8'h18; i_ready = 1'b1;
    step("fullPushPop");
    checkValue("fullPushPop.count", 32'(count), 32'd8);
    checkValue("fullPushPop.full", 32'(outFull), 32'd1);
    checkValue("fullPushPop.ovf", 32'(ovf), 32'd0);
    wO = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      checkValue("drain2.seq", 32'(o_data), 32'h10 + 32'(i));
      step("drain2");
    end
    i_ready = 1'b0;

    // Wrap-around streaming, writer respects backpressure
    written = 0; nextVal = 8'h40; maxCount = 0;
    for (int cyc = 0; cyc < 200 && (written < 40 || model.size() != 0); cyc++) begin
      i_ready = cyc[0];
      wO = (written < 40) && (model.size() < DEPTH);
      din = nextVal;
      if (wO) begin
        written++;
        nextVal = nextVal + 8'h01;
      end
      step("stream");
    end
    checkValue("stream.written", 32'(written), 32'd40);
    checkValue("stream.drained", 32'(model.size()), 32'd0);
    checkValue("stream.maxCount", 32'(maxCount <= DEPTH), 32'd1);
    checkValue("stream.noOvf", 32'(ovf), 32'd0);
    idleInputs();

    // clr mid-stream
    for (int i = 0; i < 5; i++) begin
      wO = 1'b1; din = 8'($urandom);
      step("pre.clr");
    end
    wO = 1'b0; clr = 1'b1;
    step("clr");
    clr = 1'b0;
    checkValue("clr.count", 32'(count), 32'd0);
    checkValue("clr.valid", 32'(o_valid), 32'd0);

    // Async reset between edges
    for (int i = 0; i < 3; i++) begin
      wO = 1'b1; din = 8'($urandom);
      step("refill");
    end
    wO = 1'b0;
    #2;
    i_rst_n = 1'b0;
    #1;
    model.delete();
    mOvf = 1'b0;
    checkValue("asyncRst.valid", 32'(o_valid), 32'd0);
    checkValue("asyncRst.count", 32'(count), 32'd0);
    @(posedge clk);
    #1;
    i_rst_n = 1'b1;

    // Random traffic including drops and flushes
    for (int i = 0; i < 400; i++) begin
      wO      = ($urandom_range(0, 3) != 0);
      din     = 8'($urandom);
      i_ready = ($urandom_range(0, 2) == 0);
      clr     = ($urandom_range(0, 40) == 0);
      step("rand");
    end
    idleInputs();
    step("final");

    $display("CHECKS %0d ERRORS %0d", checkCnt, errCnt);
    $finish;
  end

endmodule
